pwm_multi: RTL
==============

# pwm_multi

Parametrised multi-channel PWM generator, successor to the fixed 11-bit single-channel PWM in the motor-drive path. One shared free-running period counter drives NCH channels. Each channel has a double-buffered duty register committed only at the period boundary, plus complementary outputs. Compile-time dead-time insertion prevents shoot-through on the H-bridge drivers.

## Interface
- WIDTH, 11, counter and duty width; period = 2^WIDTH clocks
- NCH, 2, number of channels (1..8)
- DEAD, 4, dead-time in clocks (0..255, must be < 2^WIDTH); used only with the macro
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- duty  in  NCH*WIDTH  channel k duty at [k*WIDTH +: WIDTH]
- duty_wr  in  1  one-cycle strobe; captures all NCH duties into pending registers
- pend  out  1  pending update captured, not yet committed
- cyc_start  out  1  high for one clock when PWM outputs reflect cnt==0
- PWM_sig  out  NCH  PWM outputs
- PWM_sig_n  out  NCH  complementary outputs

## Operation
- cnt: WIDTH bits, reset 0, +1 every clock, wraps 2^WIDTH-1 -> 0.
- Per channel: pnd[k] (pending) and act[k] (active), both reset 0; pend reset 0.
- duty_wr=1 with cnt != max: pnd <= duty; pend <= 1. A repeated write overwrites pnd.
- cnt == max (2^WIDTH-1), pend=1, duty_wr=0: act <= pnd; pend <= 0.
- cnt == max with duty_wr=1: act <= duty (the new input); pend <= 0. The newest value always wins.
- Raw compare: r[k] <= (cnt < act[k]), registered, reset 0.
- Duty 0 gives constant low. Duty 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH clocks. 100% duty is not supported.
- cyc_start <= (cnt == 0), registered, reset 0. It is aligned with r.
- Without the macro: PWM_sig = r; PWM_sig_n = ~r.

## Timing
- Output latency is 1 clock from cnt to PWM_sig.
- A duty committed at cnt==max first appears in the period in which cyc_start is asserted (cnt==0 compare). The period in progress is never altered.
- Worst-case write-to-effect is 2^WIDTH+1 clocks. Best case, writing on the cnt==max cycle, is 1 clock to commit and 2 to the output.
- Reset values without the macro: PWM_sig=0, PWM_sig_n=all 1, pend=0, cyc_start=0.
- Reset asserted mid-period: cnt, pnd, act, r, and the dead counters clear immediately (asynchronously). Any pending write is lost.

## Configuration
- Macro PWM_DEADTIME_EN.
- When defined, each channel has a dead counter dc[k], reset 0. dc clears to 0 on the clock where r[k] changes; otherwise it increments, saturating at DEAD.
- When defined, outputs are PWM_sig[k] = r[k] && dc[k]==DEAD and PWM_sig_n[k] = !r[k] && dc[k]==DEAD.
- As a result, each rising edge is delayed by DEAD clocks and falling edges are not delayed. PWM_sig and PWM_sig_n are never high together. A raw phase of DEAD clocks or fewer produces no pulse on that output.
- When defined, reset values are PWM_sig=0 and PWM_sig_n=0. PWM_sig_n rises DEAD clocks after reset release.
- DEAD=0 with the macro is cycle-identical to the build without the macro.
- Without the macro, the DEAD parameter is ignored and no dc logic exists.

## Test plan
Benches use WIDTH=4, NCH=2 (period 16).
- Reset, no macro: hold rst_n=0 -> PWM_sig=2'b00, PWM_sig_n=2'b11, pend=0, cyc_start=0. After release, cyc_start pulses every 16 clocks.
- Write duty {ch1=0, ch0=5} at cnt=3 -> pend=1 until the clock after cnt==15. From the next cyc_start, PWM_sig[0] is high 5 of every 16 clocks; PWM_sig[1] is constant 0 and PWM_sig_n[1] is constant 1.
- Active ch0=5, write ch0=12 at cnt=7 -> the remainder of the current period still follows 5. The next period is high for 12 clocks.
- Write ch0=9 at cnt=7, then ch0=2 on the cnt==15 clock -> the next period uses 2 and pend=0 right after.
- Set ch0=15 -> PWM_sig[0] is high 15 clocks and low 1 clock per period, repeating.
- With PWM_DEADTIME_EN and DEAD=2, set ch0=6 -> PWM_sig[0] is high 4 clocks and PWM_sig_n[0] is high 8 clocks, separated by 2-clock gaps, and never both high. Then set ch0=1 -> PWM_sig[0] is never high.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared free-running period counter, NCH double-buffered duty channels.
// Define PWM_DEADTIME_EN to delay every rising edge of PWM_sig/PWM_sig_n by DEAD clocks.
module pwm_multi #(
  parameter int WIDTH = 11,
  parameter int NCH   = 2,
  parameter int DEAD  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic                 duty_wr,
  output logic                 pend,
  output logic                 cyc_start,
  output logic [NCH-1:0]       PWM_sig,
  output logic [NCH-1:0]       PWM_sig_n
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("pwm_multi: NCH must be in 1..8");
  end
  if (DEAD < 0 || DEAD > 255 || DEAD >= (2 ** WIDTH)) begin : g_bad_dead
    $error("pwm_multi: DEAD must be in 0..255 and below 2**WIDTH");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pnd [NCH];
  logic [WIDTH-1:0] act [NCH];
  logic [NCH-1:0]   r;
  logic [NCH-1:0]   r_next;
  logic             at_max;

  assign at_max = (cnt == CNT_MAX);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  // Commit happens only on the last count of a period; a write landing on that
  // same cycle bypasses the pending buffer so the newest value always wins.
  // NOTE: the duty arrays are a handful of flops, not a RAM, so they take the
  // asynchronous reset like any other state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        pnd[k] <= '0;
        act[k] <= '0;
      end
    end else if (at_max) begin
      pend <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        if (duty_wr)   act[k] <= duty[k*WIDTH +: WIDTH];
        else if (pend) act[k] <= pnd[k];
      end
    end else if (duty_wr) begin
      pend <= 1'b1;
      for (int k = 0; k < NCH; k++) pnd[k] <= duty[k*WIDTH +: WIDTH];
    end
  end

  // NOTE: every combinational output gets a default before any conditional
  // logic, so no path can leave it unassigned and infer a latch.
  always_comb begin
    r_next = '0;
    for (int k = 0; k < NCH; k++) r_next[k] = (cnt < act[k]);
  end

  // cyc_start is registered alongside r so it marks the cnt==0 compare result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      cyc_start <= 1'b0;
    end else begin
      r         <= r_next;
      cyc_start <= (cnt == '0);
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [7:0] DEAD_C = 8'(DEAD);

  logic [7:0] dc [NCH];

  // dc counts clocks since the raw compare last changed, saturating at DEAD;
  // an output may only be high once its raw phase has lasted DEAD clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) dc[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (r_next[k] != r[k]) dc[k] <= '0;
        else if (dc[k] != DEAD_C) dc[k] <= dc[k] + 8'd1;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_dead
    assign PWM_sig[k]   =  r[k] && (dc[k] == DEAD_C);
    assign PWM_sig_n[k] = !r[k] && (dc[k] == DEAD_C);
  end
`else
  assign PWM_sig   = r;
  assign PWM_sig_n = ~r;
`endif

endmodule
